// File: rtl/apb_pkg.sv
// Shared APB master definitions: FSM state encoding, request descriptor,
// default bus widths and the round-robin pick helper.
package apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   typedef struct packed {
      logic [APB_ADDR_W-1:0] addr;
      logic [APB_DATA_W-1:0] wdata;
      logic                  write;
      logic                  id;
   } apb_req_t;

   // Winner index for two requesters: on contention the one not granted last.
   function automatic logic rr_pick(input logic [1:0] valid, input logic last);
      logic pick;
      if (valid == 2'b11) begin
         pick = ~last;
      end else begin
         pick = valid[1];
      end
      return pick;
   endfunction

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter with a one-bit last-grant pointer.
module apb_rr_arb2
   import apb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   input  logic       accept,
   output logic [1:0] grant
);

   logic last_grant;
   logic pick;

   assign pick  = rr_pick(valid, last_grant);
   assign grant = (valid == 2'b00) ? 2'b00 : (pick ? 2'b10 : 2'b01);

   // Pointer resets to 1 so requester 0 wins the first contention.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= 1'b1;
      end else if (accept) begin
         last_grant <= pick;
      end
   end

endmodule

// File: rtl/apb_master_arb.sv
// Two-requester APB master: arbitrates, runs IDLE/SETUP/ACCESS and returns
// responses. Optional pready timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arb
   import apb_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TMO_CYC = 16
)
(
   input  logic              pclk,
   input  logic              preset,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [DATA_W-1:0] req_wdata0,
   input  logic [DATA_W-1:0] req_wdata1,
   input  logic [1:0]        req_write,
   output logic              rsp_valid,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_slverr,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   output logic              pwrite,
   output logic              psel,
   output logic              penable,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   apb_state_e        state;
   logic [1:0]        grant;
   logic              accept;
   logic              tmo_hit;
   logic [ADDR_W-1:0] hold_addr;
   logic [DATA_W-1:0] hold_wdata;
   logic              hold_write;
   logic              hold_id;

   assign req_ready = (state == IDLE && !preset) ? grant : 2'b00;
   assign accept    = |(req_valid & req_ready);

   assign paddr  = hold_addr;
   assign pwdata = hold_wdata;
   assign pwrite = hold_write;

   apb_rr_arb2 u_arb (
      .clk    (pclk),
      .rst    (preset),
      .valid  (req_valid),
      .accept (accept),
      .grant  (grant)
   );

`ifdef APB_ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TMO_CYC + 1);

   logic [TMO_W-1:0] tmo_cnt;

   // The stalled cycle that would bring the count to TMO_CYC ends the transfer.
   assign tmo_hit = (state == ACCESS) && !pready && (tmo_cnt == TMO_W'(TMO_CYC - 1));

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         tmo_cnt <= '0;
      end else if (state == SETUP) begin
         tmo_cnt <= '0;
      end else if (state == ACCESS && !pready) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // Phase sequencer; reset drops psel/penable immediately and discards any transfer.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state      <= IDLE;
         psel       <= 1'b0;
         penable    <= 1'b0;
         hold_addr  <= '0;
         hold_wdata <= '0;
         hold_write <= 1'b0;
         hold_id    <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_rdata  <= '0;
         rsp_slverr <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  hold_addr  <= grant[1] ? req_addr1 : req_addr0;
                  hold_wdata <= grant[1] ? req_wdata1 : req_wdata0;
                  hold_write <= grant[1] ? req_write[1] : req_write[0];
                  hold_id    <= grant[1];
                  psel       <= 1'b1;
                  state      <= SETUP;
               end
            end
            SETUP: begin
               penable <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS: begin
               if (pready || tmo_hit) begin
                  psel       <= 1'b0;
                  penable    <= 1'b0;
                  state      <= IDLE;
                  rsp_valid  <= 1'b1;
                  rsp_id     <= hold_id;
                  rsp_rdata  <= (pready && !hold_write) ? prdata : '0;
                  rsp_slverr <= pready ? pslverr : 1'b1;
               end
            end
            default: begin
               psel    <= 1'b0;
               penable <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb with a small APB slave model; the
// timeout sequence runs only when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_master_arb;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 16;

   logic          pclk = 1'b0;
   logic          preset;
   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic [AW-1:0] req_addr0;
   logic [AW-1:0] req_addr1;
   logic [DW-1:0] req_wdata0;
   logic [DW-1:0] req_wdata1;
   logic [1:0]    req_write;
   logic          rsp_valid;
   logic          rsp_id;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_slverr;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic          pwrite;
   logic          psel;
   logic          penable;
   logic [DW-1:0] prdata;
   logic          pready;
   logic          pslverr;

   int            checks = 0;
   int            errors = 0;

   int            slv_waits = 0;
   logic          slv_err = 1'b0;
   int            slv_cnt;
   logic [31:0]   mem [0:15];

   typedef struct {
      logic        id;
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic        err;
      logic [31:0] exp_rdata;
      logic        exp_slverr;
      int          exp_lat;
   } vec_t;

   vec_t vecs [7];

   always #5 pclk = ~pclk;

   apb_master_arb #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(TMO)) dut (
      .pclk       (pclk),
      .preset     (preset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr0  (req_addr0),
      .req_addr1  (req_addr1),
      .req_wdata0 (req_wdata0),
      .req_wdata1 (req_wdata1),
      .req_write  (req_write),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_rdata  (rsp_rdata),
      .rsp_slverr (rsp_slverr),
      .paddr      (paddr),
      .pwdata     (pwdata),
      .pwrite     (pwrite),
      .psel       (psel),
      .penable    (penable),
      .prdata     (prdata),
      .pready     (pready),
      .pslverr    (pslverr)
   );

   // Slave model: word memory, programmable wait states and error flag.
   always @(posedge pclk or posedge preset) begin
      if (preset) begin
         slv_cnt <= 0;
         for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else if (psel && penable) begin
         if (pready) begin
            if (pwrite) mem[paddr[5:2]] <= pwdata;
            slv_cnt <= 0;
         end else begin
            slv_cnt <= slv_cnt + 1;
         end
      end else begin
         slv_cnt <= 0;
      end
   end

   always_comb begin
      pready  = psel && penable && (slv_cnt >= slv_waits);
      prdata  = mem[paddr[5:2]];
      pslverr = pready && slv_err;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Issues one request and measures cycles from the accept edge to rsp_valid.
   task automatic applyStimulus(input logic id, input logic write, input logic [31:0] addr,
                                input logic [31:0] wdata, input int waits, input logic err,
                                output int lat, output logic got_id, output logic [31:0] got_rdata,
                                output logic got_err, output int unstable, output logic setup_ok);
      int n;
      lat       = -1;
      got_id    = 1'bx;
      got_rdata = 'x;
      got_err   = 1'bx;
      unstable  = 0;
      setup_ok  = 1'b1;
      @(negedge pclk);
      slv_waits     = waits;
      slv_err       = err;
      req_write[id] = write;
      if (id) begin
         req_addr1  = addr;
         req_wdata1 = wdata;
      end else begin
         req_addr0  = addr;
         req_wdata0 = wdata;
      end
      req_valid[id] = 1'b1;
      #1;
      n = 0;
      while (!req_ready[id] && n < 20) begin
         @(negedge pclk);
         #1;
         n++;
      end
      if (n >= 20) begin
         req_valid[id] = 1'b0;
         return;
      end
      @(negedge pclk);
      req_valid[id] = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 60) begin
         if (lat == 1 && !(psel && !penable)) setup_ok = 1'b0;
         if (lat == 2 && !(psel && penable)) setup_ok = 1'b0;
         if (psel && (paddr != addr || pwrite != write || (write && pwdata != wdata))) unstable++;
         @(negedge pclk);
         lat++;
      end
      got_id    = rsp_id;
      got_rdata = rsp_rdata;
      got_err   = rsp_slverr;
   endtask

   initial begin
      int          lat;
      int          unstable;
      int          n;
      int          nrsp;
      int          cyc;
      int          rem [2];
      int          grants [$];
      int          gcyc [$];
      logic        got_id;
      logic        got_err;
      logic        setup_ok;
      logic [31:0] got_rdata;

      vecs[0] = '{1'b0, 1'b1, 32'h4,  32'hA5A5_0001, 0, 1'b0, 32'h0,         1'b0, 3};
      vecs[1] = '{1'b1, 1'b0, 32'h4,  32'h0,         0, 1'b0, 32'hA5A5_0001, 1'b0, 3};
      vecs[2] = '{1'b0, 1'b1, 32'h8,  32'h1234_5678, 3, 1'b0, 32'h0,         1'b0, 6};
      vecs[3] = '{1'b1, 1'b0, 32'h8,  32'h0,         1, 1'b0, 32'h1234_5678, 1'b0, 4};
      vecs[4] = '{1'b1, 1'b1, 32'hC,  32'hDEAD_BEEF, 0, 1'b1, 32'h0,         1'b1, 3};
      vecs[5] = '{1'b0, 1'b0, 32'hC,  32'h0,         2, 1'b1, 32'hDEAD_BEEF, 1'b1, 5};
      vecs[6] = '{1'b0, 1'b0, 32'h10, 32'h0,         0, 1'b0, 32'h0,         1'b0, 3};

      preset     = 1'b0;
      req_valid  = 2'b11;
      req_write  = 2'b00;
      req_addr0  = '0;
      req_addr1  = '0;
      req_wdata0 = '0;
      req_wdata1 = '0;
      #2;
      preset = 1'b1;
      repeat (2) @(negedge pclk);
      checkOutput("reset_psel", psel, 0);
      checkOutput("reset_penable", penable, 0);
      checkOutput("reset_pwrite", pwrite, 0);
      checkOutput("reset_paddr", paddr, 0);
      checkOutput("reset_pwdata", pwdata, 0);
      checkOutput("reset_rsp_valid", rsp_valid, 0);
      checkOutput("reset_rsp_rdata", rsp_rdata, 0);
      checkOutput("reset_req_ready", req_ready, 0);
      req_valid = 2'b00;
      @(negedge pclk);
      preset = 1'b0;

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].id, vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
                       vecs[i].err, lat, got_id, got_rdata, got_err, unstable, setup_ok);
         checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
         checkOutput($sformatf("v%0d_rsp_id", i), got_id, vecs[i].id);
         checkOutput($sformatf("v%0d_rsp_rdata", i), got_rdata, vecs[i].exp_rdata);
         checkOutput($sformatf("v%0d_rsp_slverr", i), got_err, vecs[i].exp_slverr);
         checkOutput($sformatf("v%0d_bus_stable", i), unstable, 0);
         checkOutput($sformatf("v%0d_setup_access", i), setup_ok, 1);
         @(negedge pclk);
         checkOutput($sformatf("v%0d_rsp_pulse", i), rsp_valid, 0);
      end

      // Reset during ACCESS: bus drops at once and no response is produced.
      @(negedge pclk);
      slv_waits     = 5;
      slv_err       = 1'b0;
      req_addr0     = 32'h20;
      req_wdata0    = 32'h5555_AAAA;
      req_write[0]  = 1'b1;
      req_valid[0]  = 1'b1;
      n = 0;
      while (!penable && n < 20) begin
         @(negedge pclk);
         n++;
      end
      req_valid = 2'b11;
      checkOutput("rst_reached_access", penable, 1);
      #2;
      preset = 1'b1;
      #1;
      checkOutput("rst_psel_async", psel, 0);
      checkOutput("rst_penable_async", penable, 0);
      @(negedge pclk);
      checkOutput("rst_req_ready_low", req_ready, 0);
      req_valid = 2'b00;
      preset    = 1'b0;
      nrsp = 0;
      repeat (10) begin
         @(negedge pclk);
         if (rsp_valid) nrsp++;
      end
      checkOutput("rst_no_response", nrsp, 0);

      // Contention: both requesters stay valid for four transfers each.
      slv_waits  = 0;
      slv_err    = 1'b0;
      req_addr0  = 32'h30;
      req_wdata0 = 32'h0000_0A00;
      req_addr1  = 32'h34;
      req_wdata1 = 32'h0000_0B00;
      req_write  = 2'b11;
      rem[0] = 4;
      rem[1] = 4;
      cyc  = 0;
      nrsp = 0;
      @(negedge pclk);
      req_valid = 2'b11;
      while ((grants.size() < 8 || nrsp < 8) && cyc < 200) begin
         #1;
         if (rsp_valid) nrsp++;
         for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               grants.push_back(i);
               gcyc.push_back(cyc);
               rem[i]--;
            end
         end
         @(negedge pclk);
         cyc++;
         for (int i = 0; i < 2; i++) begin
            if (rem[i] <= 0) req_valid[i] = 1'b0;
         end
      end
      req_valid = 2'b00;
      repeat (5) begin
         @(negedge pclk);
         if (rsp_valid) nrsp++;
      end
      checkOutput("cont_grant_count", grants.size(), 8);
      for (int k = 0; k < 8; k++) begin
         if (k < grants.size()) checkOutput($sformatf("cont_grant%0d", k), grants[k], k % 2);
      end
      if (gcyc.size() == 8) checkOutput("cont_spacing", gcyc[7] - gcyc[0], 21);
      checkOutput("cont_responses", nrsp, 8);

`ifdef APB_ARB_TIMEOUT_EN
      applyStimulus(1'b1, 1'b0, 32'h4, 32'h0, 1000, 1'b0,
                    lat, got_id, got_rdata, got_err, unstable, setup_ok);
      checkOutput("tmo_latency", lat, TMO + 2);
      checkOutput("tmo_rsp_id", got_id, 1);
      checkOutput("tmo_rsp_slverr", got_err, 1);
      checkOutput("tmo_rsp_rdata", got_rdata, 0);
      applyStimulus(1'b0, 1'b1, 32'h4, 32'h0000_7777, 0, 1'b0,
                    lat, got_id, got_rdata, got_err, unstable, setup_ok);
      checkOutput("tmo_next_latency", lat, 3);
      checkOutput("tmo_next_slverr", got_err, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_master_arb.md
# apb_master_arb

Two-port APB master that arbitrates between two local requesters and runs their transfers on one APB bus toward the `apb_s` slave. It owns the APB phase sequencing (IDLE → SETUP → ACCESS) and waits for `pready`. It returns read data and the error status to the requester that issued the transfer. It sits between on-chip initiators and the existing `apb_s` register slave, and the team's environment drives its request ports in place of the testbench driver.

## Interface
Parameters:
- `ADDR_W`, default 32: APB address width.
- `DATA_W`, default 32: APB data width.
- `TMO_CYC`, default 16: `pready` wait limit in ACCESS cycles. Used only with `APB_ARB_TIMEOUT_EN`.

Ports:
- `pclk`, in, 1: clock. All logic is on the rising edge.
- `preset`, in, 1: reset, asynchronous and active-high.
- `req_valid`, in, 2: per-requester request valid (bit i = requester i).
- `req_ready`, out, 2: per-requester accept; a request is taken when `valid & ready`.
- `req_addr0`, `req_addr1`, in, ADDR_W: transfer address per requester.
- `req_wdata0`, `req_wdata1`, in, DATA_W: write data per requester.
- `req_write`, in, 2: 1 = write, 0 = read, per requester.
- `rsp_valid`, out, 1: one-cycle response pulse.
- `rsp_id`, out, 1: requester that owns the response.
- `rsp_rdata`, out, DATA_W: read data (0 for writes).
- `rsp_slverr`, out, 1: slave error or timeout.
- `paddr`, `pwdata`, `pwrite`, `psel`, `penable`: out, APB master outputs.
- `prdata`, `pready`, `pslverr`: in, APB slave returns.

## Operation
- FSM states are IDLE, SETUP and ACCESS.
- **IDLE**
  - `req_ready` is combinational: only the granted requester sees ready, and only in IDLE.
  - On accept, the block latches addr, wdata, write and id into holding registers, then goes to SETUP.
- **Arbitration**
  - Round-robin with a 1-bit last-grant pointer; reset value 1, so requester 0 wins first.
  - If only one requester is valid, it is granted.
  - If both are valid, the one that is not the last grant wins.
  - The pointer updates on accept only.
- **SETUP**
  - `psel=1`, `penable=0`, and `paddr`/`pwdata`/`pwrite` come from the holding registers.
  - The FSM always moves to ACCESS on the next cycle.
- **ACCESS**
  - `psel=1`, `penable=1`, address and data held stable.
  - If `pready=0`, stay in ACCESS.
  - If `pready=1`, capture `prdata` (reads only; writes capture 0) and `pslverr`, then go to IDLE.
- **Response**
  - The captured response appears as a `rsp_valid` pulse in the cycle after the `pready` cycle.
  - `rsp_id` is the latched id.
- No back-to-back SETUP: every transfer returns to IDLE.
- A new request may be accepted in the same cycle that `rsp_valid` is high.
- `pslverr` is passed through unchanged. No retry is attempted.

## Timing
- Reset values: `psel`, `penable`, `pwrite`, `rsp_valid`, `rsp_id`, `rsp_slverr` = 0; `paddr`, `pwdata`, `rsp_rdata` = 0; `req_ready` = 0 while `preset` is high.
- Zero-wait transfer, with accept at cycle T:
  - T+1: SETUP.
  - T+2: ACCESS, with `pready=1`.
  - T+3: `rsp_valid`. The next accept is also possible at T+3.
- Throughput: at most one transfer per 3 cycles.
- Each cycle of `pready=0` adds one ACCESS cycle and delays `rsp_valid` by one cycle.
- `preset` asserted mid-transfer:
  - `psel`/`penable` drop immediately (asynchronously).
  - The FSM returns to IDLE and the in-flight transfer is dropped with no response.
- `pready`/`pslverr` outside ACCESS are ignored.

## Configuration
- `APB_ARB_TIMEOUT_EN` defined:
  - A counter clears on entering ACCESS and counts each ACCESS cycle with `pready=0`.
  - When the count reaches `TMO_CYC`, the transfer ends: FSM goes to IDLE, `rsp_slverr=1`, `rsp_rdata=0`.
  - `rsp_valid` pulses on the next cycle.
  - The counter width is $clog2(TMO_CYC+1).
- Not defined: no counter exists, and the block waits for `pready` indefinitely.

## Structure
- Shared package `apb_pkg` holds:
  - `apb_state_e` (IDLE/SETUP/ACCESS);
  - a `apb_req_t` struct (addr, wdata, write, id);
  - default width constants `APB_ADDR_W` and `APB_DATA_W`.
- One sub-module, `apb_rr_arb2`: 2-way round-robin grant logic (valid[1:0], accept, grant[1:0], pointer register).
- The FSM and holding registers stay in the top module.

## Test plan
- Single write, zero-wait: req0 writes 0xA5A5_0001 to addr 0x4. `psel` rises at T+1, `penable` at T+2, `rsp_valid` at T+3 with `rsp_id=0`, `rsp_slverr=0`.
- Read-back: req1 reads addr 0x4 after that write. `rsp_rdata=0xA5A5_0001`, `rsp_id=1`, and `pwrite=0` throughout.
- Contention: both requesters valid continuously, 4 transfers each. Grants alternate 0,1,0,1,…, no requester is starved, and there are exactly 8 responses.
- Wait states: `pready` held low for 3 ACCESS cycles. `paddr`/`pwdata` are stable throughout, and `rsp_valid` arrives at T+6.
- Error and reset:
  - `pslverr=1` with `pready` gives `rsp_slverr=1`.
  - `preset` pulsed during ACCESS drops `psel` asynchronously, and no `rsp_valid` follows.
- Timeout (`APB_ARB_TIMEOUT_EN` defined, `TMO_CYC=16`): `pready` held low gives `rsp_slverr=1` after 16 ACCESS cycles, then the FSM returns to IDLE and accepts the next request.
